// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial sequence detector.
// Optional match counter is enabled with `define SEQDET_COUNT_EN.
package seq_det_pkg;

  typedef enum logic {
    NON_OVL = 1'b0,
    OVL     = 1'b1
  } ovl_e;

  localparam logic [7:0] SD_DEF_PATTERN = 8'b0000_1010;
  localparam int         SD_DEF_LEN     = 4;
  localparam ovl_e       SD_DEF_OVL     = NON_OVL;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter; clear has priority over increment.
// Instantiated only when SEQDET_COUNT_EN is defined.
module seq_det_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector (Mealy, MSB first).
// Define SEQDET_COUNT_EN to build the saturating Match_count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(SD_DEF_PATTERN),
  parameter int               DEF_LEN     = SD_DEF_LEN,
  parameter bit               DEF_OVL     = SD_DEF_OVL
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Cfg_load,
  input  logic [PAT_W-1:0]          Cfg_pattern,
  input  logic [len_w(PAT_W)-1:0]   Cfg_len,
  input  logic                      Cfg_ovl,
  input  logic                      D,
  input  logic                      D_valid,
  input  logic                      Cnt_clr,
  output logic                      Y,
  output logic                      Y_q,
  output logic [CNT_W-1:0]          Match_count
);

  localparam int LEN_W = len_w(PAT_W);
  localparam int HW    = PAT_W - 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  ovl_e             ovl;
  logic [HW-1:0]    hist;
  logic [LEN_W-1:0] fill;
  logic             yq_r;

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len_c;
  logic [LEN_W-1:0] fill_nx;
  logic             y_c;

  always_comb begin
    len_c = (Cfg_len > LEN_MAX) ? LEN_MAX : Cfg_len;
    win   = {hist, D};
    mask  = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    y_c = D_valid & ~Cfg_load & ~Rst & (len != '0) &
          (fill >= len - 1'b1) &
          ((win & mask) == (pat & mask));
    // Non-overlap restarts the fill so matched bits are consumed
    if (y_c && (ovl == NON_OVL)) begin
      fill_nx = '0;
    end else if (fill == FILL_MAX) begin
      fill_nx = fill;
    end else begin
      fill_nx = fill + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pat  <= DEF_PATTERN;
      len  <= LEN_W'(DEF_LEN);
      ovl  <= ovl_e'(DEF_OVL);
      hist <= '0;
      fill <= '0;
      yq_r <= 1'b0;
    end else begin
      yq_r <= y_c;
      if (Cfg_load) begin
        pat  <= Cfg_pattern;
        len  <= len_c;
        ovl  <= ovl_e'(Cfg_ovl);
        hist <= '0;
        fill <= '0;
      end else if (D_valid) begin
        hist <= win[HW-1:0];
        fill <= fill_nx;
      end
    end
  end

  assign Y   = y_c;
  assign Y_q = yq_r;

`ifdef SEQDET_COUNT_EN
  seq_det_match_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .inc  (y_c),
    .clr  (Cnt_clr),
    .count(Match_count)
  );
`else
  logic unused_clr;
  assign unused_clr  = Cnt_clr;
  assign Match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed bit streams.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pat = 8'h0A;
  logic [3:0] cfg_len = 4'd4;
  logic       cfg_ovl = 1'b0;
  logic       din = 1'b0;
  logic       dv = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       y, yq, y2, yq2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  typedef struct {
    logic       y;
    logic       yq;
    logic [7:0] c;
    logic [1:0] c2;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic       m_yq = 1'b0;
  logic [7:0] m_c  = '0;
  logic [1:0] m_c2 = '0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(8), .CNT_W(8)) dut (
    .Clk(clk), .Rst(rst), .Cfg_load(cfg_load),
    .Cfg_pattern(cfg_pat), .Cfg_len(cfg_len), .Cfg_ovl(cfg_ovl),
    .D(din), .D_valid(dv), .Cnt_clr(cnt_clr),
    .Y(y), .Y_q(yq), .Match_count(cnt)
  );

  seq_detector_param #(.PAT_W(8), .CNT_W(2)) dut2 (
    .Clk(clk), .Rst(rst), .Cfg_load(cfg_load),
    .Cfg_pattern(cfg_pat), .Cfg_len(cfg_len), .Cfg_ovl(cfg_ovl),
    .D(din), .D_valid(dv), .Cnt_clr(cnt_clr),
    .Y(y2), .Y_q(yq2), .Match_count(cnt2)
  );

  function automatic void chk(input string tag, input string what,
                              input logic [7:0] act,
                              input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h want %0h", tag, what, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "Y", {7'd0, y}, {7'd0, e.y});
      chk(e.tag, "Y2", {7'd0, y2}, {7'd0, e.y});
      chk(e.tag, "Y_q", {7'd0, yq}, {7'd0, e.yq});
      chk(e.tag, "Y_q2", {7'd0, yq2}, {7'd0, e.yq});
      chk(e.tag, "count", cnt, e.c);
      chk(e.tag, "count2", {6'd0, cnt2}, {6'd0, e.c2});
    end
  end

  task automatic step(input logic r, input logic ld, input logic d,
                      input logic v, input logic clr, input logic ey,
                      input string tag);
    exp_t e;
    rst = r; cfg_load = ld; din = d; dv = v; cnt_clr = clr;
    if (r) begin
      m_yq = 1'b0; m_c = '0; m_c2 = '0; ey = 1'b0;
    end
    e = '{ey, m_yq, m_c, m_c2, tag};
    sb.push_back(e);
    @(posedge clk);
    if (!r) begin
      m_yq = ey;
`ifdef SEQDET_COUNT_EN
      if (clr) begin
        m_c = '0; m_c2 = '0;
      end else if (ey) begin
        if (m_c != 8'hFF) m_c = m_c + 8'd1;
        if (m_c2 != 2'b11) m_c2 = m_c2 + 2'd1;
      end
`endif
    end
    #1;
  endtask

  task automatic stream(input logic [15:0] bits, input int n,
                        input logic [15:0] ys, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b0, bits[i], 1'b1, 1'b0, ys[i], tag);
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l,
                      input logic o, input string tag);
    cfg_pat = p; cfg_len = l; cfg_ovl = o;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset_a");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset_b");
    stream(16'b1010_1010, 8, 16'b0001_0001, "def_nonovl");
    load(8'h0A, 4'd4, 1'b1, "load_ovl");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr_idle");
    stream(16'b1010_1010, 8, 16'b0001_0101, "ovl");
    load(8'hB3, 4'd8, 1'b0, "load_b3");
    stream(16'b1011, 4, 16'b0000, "gap_pre");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap");
    stream(16'b0011, 4, 16'b0001, "gap_post");
    load(8'hB3, 4'd0, 1'b0, "load_len0");
    stream(16'b1011_0011_0101_1010, 16, 16'h0000, "len0");
    load(8'hB3, 4'd15, 1'b0, "load_len15");
    stream(16'b1011_0011, 8, 16'b0000_0001, "len15");
    load(8'h01, 4'd1, 1'b0, "load_len1");
    stream(16'b11111, 5, 16'b11111, "sat");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "clr_match");
    stream(16'b01, 2, 16'b01, "after_clr");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_pulse");
    stream(16'b101, 3, 16'b000, "pre_rst");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_mid");
    stream(16'b01010, 5, 16'b00001, "post_rst");
    cfg_pat = 8'h0A; cfg_len = 4'd4; cfg_ovl = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "load_dv");
    stream(16'b010, 3, 16'b000, "ld_a");
    stream(16'b10, 2, 16'b01, "ld_b");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "tail");
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
